// File: rtl/am_disp_scan.sv
// Display stage for AM: captures Out/Ovf on Load and scans four hex digits onto a
// common-anode 7-segment display, showing dashes on overflow. Optional macro: AM_DISP_LZB_EN.
module am_disp_scan #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Load,
    input  logic [15:0] Out,
    input  logic        Ovf,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        Valid
);

    localparam logic [1:0] DIG0 = 2'd0;
    localparam logic [1:0] DIG1 = 2'd1;
    localparam logic [1:0] DIG2 = 2'd2;
    localparam logic [1:0] DIG3 = 2'd3;

    localparam logic [15:0] PCNT_MAX  = 16'(SCAN_DIV - 1);
    localparam logic [6:0]  SEG_DARK  = 7'b1111111;
    localparam logic [6:0]  SEG_DASH  = 7'b0111111;

    logic [15:0] val_q, val_d;
    logic        ovf_q, ovf_d;
    logic        valid_q, valid_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [1:0]  dig_q, dig_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  nibble;
    logic        blank;

    // Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        val_d   = val_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        if (Load) begin
            val_d   = Out;
            ovf_d   = Ovf;
            valid_d = 1'b1;
        end

        // The scan runs regardless of Load/Valid so a capture never restarts it.
        pcnt_d = pcnt_q + 16'd1;
        dig_d  = dig_q;
        if (pcnt_q == PCNT_MAX) begin
            pcnt_d = 16'd0;
            case (dig_q)
                DIG0:    dig_d = DIG1;
                DIG1:    dig_d = DIG2;
                DIG2:    dig_d = DIG3;
                default: dig_d = DIG0;
            endcase
        end

        nibble = 4'h0;
        an_d   = 4'b1111;
        case (dig_q)
            DIG0: begin nibble = val_q[3:0];   an_d = 4'b1110; end
            DIG1: begin nibble = val_q[7:4];   an_d = 4'b1101; end
            DIG2: begin nibble = val_q[11:8];  an_d = 4'b1011; end
            default: begin nibble = val_q[15:12]; an_d = 4'b0111; end
        endcase

`ifdef AM_DISP_LZB_EN
        // A digit is blank when it and every digit to its left are zero; digit 0 always shows.
        case (dig_q)
            DIG1:    blank = (val_q[15:4]  == 12'd0);
            DIG2:    blank = (val_q[15:8]  == 8'd0);
            DIG3:    blank = (val_q[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif

        if (!valid_q) begin
            an_d  = 4'b1111;
            seg_d = SEG_DARK;
        end else if (ovf_q) begin
            seg_d = SEG_DASH;
        end else if (blank) begin
            seg_d = SEG_DARK;
        end else begin
            seg_d = hex7(nibble);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q   <= 16'd0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            pcnt_q  <= 16'd0;
            dig_q   <= DIG0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_DARK;
        end else begin
            val_q   <= val_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            pcnt_q  <= pcnt_d;
            dig_q   <= dig_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign AN    = an_q;
    assign SEG   = seg_q;
    assign Valid = valid_q;

endmodule

// File: tb/tb_am_disp_scan.sv
// Directed, table-driven bench for am_disp_scan with SCAN_DIV=2.
module tb_am_disp_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Load = 1'b0;
    logic [15:0] Out = 16'd0;
    logic        Ovf = 1'b0;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        Valid;

    am_disp_scan #(.SCAN_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .Load(Load), .Out(Out), .Ovf(Ovf),
        .AN(AN), .SEG(SEG), .Valid(Valid)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] S_DARK = 7'b1111111;
    localparam logic [6:0] S_DASH = 7'b0111111;
    localparam logic [6:0] S_0 = 7'b1000000;
    localparam logic [6:0] S_1 = 7'b1111001;
    localparam logic [6:0] S_2 = 7'b0100100;
    localparam logic [6:0] S_5 = 7'b0010010;
    localparam logic [6:0] S_8 = 7'b0000000;
    localparam logic [6:0] S_A = 7'b0001000;
    localparam logic [6:0] S_F = 7'b0001110;
`ifdef AM_DISP_LZB_EN
    localparam logic [6:0] S_LZ = S_DARK;
`else
    localparam logic [6:0] S_LZ = S_0;
`endif

    typedef struct {
        logic        load;
        logic [15:0] out;
        logic        ovf;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        valid;
    } vec_t;

    localparam int NV = 42;
    vec_t vecs[1:NV];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int idx, input logic [6:0] act, input logic [6:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0d: got %b, expected %b", name, idx, act, exp);
    endtask

    // Expected outputs after edge e (edges counted from reset release).
    task automatic set(input int e, input logic [3:0] an, input logic [6:0] seg, input logic v);
        vecs[e].an = an; vecs[e].seg = seg; vecs[e].valid = v;
    endtask

    task automatic ld(input int e, input logic [15:0] o, input logic f);
        vecs[e].load = 1'b1; vecs[e].out = o; vecs[e].ovf = f;
    endtask

    initial begin
        for (int e = 1; e <= NV; e++) begin
            vecs[e].load = 1'b0; vecs[e].out = 16'hDEAD; vecs[e].ovf = 1'b1;
            set(e, 4'b1111, S_DARK, (e >= 11));
        end
        // Normal value 12AF: capture at edge 11, frame visible from edge 12.
        ld(11, 16'h12AF, 1'b0);
        set(12, 4'b1101, S_A, 1);
        set(13, 4'b1011, S_2, 1); set(14, 4'b1011, S_2, 1);
        set(15, 4'b0111, S_1, 1); set(16, 4'b0111, S_1, 1);
        set(17, 4'b1110, S_F, 1); set(18, 4'b1110, S_F, 1);
        set(19, 4'b1101, S_A, 1); set(20, 4'b1101, S_A, 1);
        // Overflow: dashes on every digit.
        ld(21, 16'hFFFF, 1'b1);
        set(21, 4'b1011, S_2, 1);
        set(22, 4'b1011, S_DASH, 1);
        set(23, 4'b0111, S_DASH, 1); set(24, 4'b0111, S_DASH, 1);
        set(25, 4'b1110, S_DASH, 1); set(26, 4'b1110, S_DASH, 1);
        // 0003 then reload 0008 while digit 2 is active; scan continues unbroken.
        ld(27, 16'h0003, 1'b0);
        set(27, 4'b1101, S_DASH, 1);
        set(28, 4'b1101, S_LZ, 1);
        ld(29, 16'h0008, 1'b0);
        set(29, 4'b1011, S_LZ, 1); set(30, 4'b1011, S_LZ, 1);
        set(31, 4'b0111, S_LZ, 1); set(32, 4'b0111, S_LZ, 1);
        set(33, 4'b1110, S_8, 1);  set(34, 4'b1110, S_8, 1);
        // 0005 loaded on the terminal-count edge 36: new digit and new value together.
        set(35, 4'b1101, S_LZ, 1);
        ld(36, 16'h0005, 1'b0);
        set(36, 4'b1101, S_LZ, 1);
        set(37, 4'b1011, S_LZ, 1); set(38, 4'b1011, S_LZ, 1);
        set(39, 4'b0111, S_LZ, 1); set(40, 4'b0111, S_LZ, 1);
        set(41, 4'b1110, S_5, 1);  set(42, 4'b1110, S_5, 1);

        repeat (3) @(posedge clk);
        #1;
        check("rst_an", 0, {3'b0, AN}, 7'b0001111);
        check("rst_seg", 0, SEG, S_DARK);
        check("rst_valid", 0, {6'b0, Valid}, 7'd0);
        #1 rst_n = 1'b1;

        for (int e = 1; e <= NV; e++) begin
            Load = vecs[e].load; Out = vecs[e].out; Ovf = vecs[e].ovf;
            @(posedge clk);
            #1;
            Load = 1'b0;
            check("an", e, {3'b0, AN}, {3'b0, vecs[e].an});
            check("seg", e, SEG, vecs[e].seg);
            check("valid", e, {6'b0, Valid}, {6'b0, vecs[e].valid});
        end

        // Asynchronous reset between edges clears outputs without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("async_an", 0, {3'b0, AN}, 7'b0001111);
        check("async_seg", 0, SEG, S_DARK);
        check("async_valid", 0, {6'b0, Valid}, 7'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Dark until the next Load, then 0000 shows a single zero on digit 0.
        for (int e = 1; e <= 9; e++) begin
            Load = (e == 5); Out = 16'h0000; Ovf = 1'b0;
            @(posedge clk);
            #1;
            Load = 1'b0;
            if (e <= 4) begin
                check("post_rst_valid", e, {6'b0, Valid}, 7'd0);
                check("post_rst_an", e, {3'b0, AN}, 7'b0001111);
            end else if (e == 6) begin
                check("zero_d2_an", e, {3'b0, AN}, 7'b0001011);
                check("zero_d2_seg", e, SEG, S_LZ);
            end else if (e == 9) begin
                check("zero_d0_an", e, {3'b0, AN}, 7'b0001110);
                check("zero_d0_seg", e, SEG, S_0);
                check("zero_valid", e, {6'b0, Valid}, 7'd1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
